// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32x32 register file with two combinational read ports and one write port
//
// Parameters:
//   BYPASS      1: a read of the register being written returns the incoming write data
//                  in the same cycle.
//               0: reads return the stored (old) value until the write edge.
// Ports:
//   i_clk       clock; all state updates on the rising edge
//   i_rst_n     asynchronous active-low reset; clears x1..x31 and forces reads to zero
//   i_rs1_addr  read address, operand A      o_rs1_data  operand A data
//   i_rs2_addr  read address, operand B      o_rs2_data  operand B data
//   i_rd_addr   write address                i_rd_data   write data
//   i_rd_wren   write enable (writes to x0 are discarded)

module regfile_2r1w #(
    parameter int unsigned BYPASS = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data,
    input  logic        i_rd_wren
);

    // Entry 0 exists only so that the array can be indexed by any 5-bit address;
    // it is cleared by reset and never written.
    logic [31:0] regs [32];

    // A write is qualified only when the destination is a known, non-zero address.
    // Comparing each index separately means an X address never matches any entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (i_rd_wren && (i_rd_addr == 5'(i))) begin
                    regs[i] <= i_rd_data;
                end
            end
        end
    end

    // Forwarding applies only to a qualified, non-x0 write while out of reset.
    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] value;
        value = 32'h0;
        if (!i_rst_n || (addr == 5'd0)) begin
            value = 32'h0;
        end else if ((BYPASS != 0) && i_rd_wren && (i_rd_addr != 5'd0) && (i_rd_addr == addr)) begin
            value = i_rd_data;
        end else begin
            value = regs[addr];
        end
        return value;
    endfunction

    always_comb begin
        o_rs1_data = read_port(i_rs1_addr);
        o_rs2_data = read_port(i_rs2_addr);
    end

endmodule
